// File: rtl/switch_debounce_if.sv
// rtl/switch_debounce_if.sv - switch bank interface: raw levels in, debounced vector and change strobe out
// Optional event_count output is present when SWITCH_EVENT_COUNT_EN is defined.
interface switch_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] s_raw;
    logic [WIDTH-1:0] s_clean;
    logic             changed;
`ifdef SWITCH_EVENT_COUNT_EN
    logic [7:0]       event_count;
`endif

    modport master (
        output s_raw,
        input  s_clean,
        input  changed
`ifdef SWITCH_EVENT_COUNT_EN
        ,
        input  event_count
`endif
    );

    modport slave (
        input  s_raw,
        output s_clean,
        output changed
`ifdef SWITCH_EVENT_COUNT_EN
        ,
        output event_count
`endif
    );
endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - per-bit synchronizer and debouncer with one-cycle change strobe
// Optional feature macro: SWITCH_EVENT_COUNT_EN (8-bit wrapping count of change strobes).
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                 int_osc,
    input  logic                 reset_n,
    switch_debounce_if.slave     sw
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] s_clean_q;
    logic [WIDTH-1:0] s_clean_d;
    logic             changed_q;
    logic             changed_d;
`ifdef SWITCH_EVENT_COUNT_EN
    logic [7:0]       event_count_q;
    logic [7:0]       event_count_d;
`endif

    always_comb begin
        sync_d[0] = sw.s_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end

        // A bit flips only after the synchronized level has disagreed with the
        // output for DEBOUNCE_CYCLES consecutive edges; any agreement restarts it.
        s_clean_d = s_clean_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[SYNC_STAGES-1][i] != s_clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    s_clean_d[i] = sync_q[SYNC_STAGES-1][i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        changed_d = |(s_clean_d ^ s_clean_q);
`ifdef SWITCH_EVENT_COUNT_EN
        event_count_d = event_count_q + {7'd0, changed_d};
`endif
    end

    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            s_clean_q     <= '0;
            changed_q     <= 1'b0;
`ifdef SWITCH_EVENT_COUNT_EN
            event_count_q <= '0;
`endif
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            s_clean_q     <= s_clean_d;
            changed_q     <= changed_d;
`ifdef SWITCH_EVENT_COUNT_EN
            event_count_q <= event_count_d;
`endif
        end
    end

    assign sw.s_clean     = s_clean_q;
    assign sw.changed     = changed_q;
`ifdef SWITCH_EVENT_COUNT_EN
    assign sw.event_count = event_count_q;
`endif
endmodule
